// File: rtl/hs_lane_sequencer_pkg.sv
// hs_lane_sequencer_pkg: lane FSM states, sync byte, LP level constants and per-state output decode
package hs_lane_sequencer_pkg;
  typedef enum logic [2:0] {STOP, LP_RQST, LP_PREP, HS_ZERO, SYNC, DATA, TRAIL, EXIT} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hB8;
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;
  function automatic logic [1:0] lp_level(state_t s);
    return s == LP_RQST ? LP01 : (s == STOP || s == EXIT) ? LP11 : LP00;
  endfunction
  function automatic logic hs_on(state_t s);
    return s inside {HS_ZERO, SYNC, DATA, TRAIL};
  endfunction
endpackage

// File: rtl/hs_lane_sequencer_if.sv
// hs_lane_sequencer_if: PPI request/data/ready plus LP levels, HS enable and DDR bit pair; master = PPI/PHY side, slave = sequencer
interface hs_lane_sequencer_if;
  logic       TxRequestHS;
  logic [7:0] TxDataHS;
  logic       TxReadyHS;
  logic       Stopstate;
  logic       LP_Dp;
  logic       LP_Dn;
  logic       HS_Enable;
  logic       Serial_B1;
  logic       Serial_B2;
  modport master (output TxRequestHS, TxDataHS, input TxReadyHS, Stopstate, LP_Dp, LP_Dn, HS_Enable, Serial_B1, Serial_B2);
  modport slave (input TxRequestHS, TxDataHS, output TxReadyHS, Stopstate, LP_Dp, LP_Dn, HS_Enable, Serial_B1, Serial_B2);
endinterface

// File: rtl/hs_lane_sequencer_serializer.sv
// hs_byte_serializer: byte shift register emitting LSB-first bit pairs (b1 even, b2 odd), phase counter, ld strobe loads d, clr zeroes phase
module hs_byte_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       ld,
  input  logic [7:0] d,
  output logic       b1,
  output logic       b2,
  output logic       last,
  output logic       pre_last
);
  logic [7:0] sr;
  logic [1:0] phase;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      phase <= '0;
    end else begin
      sr <= ld ? d : {sr[7], sr[7], sr[7:2]};
      phase <= clr ? 2'd0 : phase + 2'd1;
    end
  assign b1 = sr[0];
  assign b2 = sr[1];
  assign last = phase == 2'd3;
  assign pre_last = phase == 2'd2;
endmodule

// File: rtl/hs_lane_sequencer.sv
// hs_lane_sequencer: D-PHY TX lane LP->HS entry, byte serialization, trail and exit; ports TX_DDR_clk, TX_rst_n, bus (slave)
module hs_lane_sequencer
  import hs_lane_sequencer_pkg::*;
#(
  parameter int T_LPX = 8,
  parameter int T_HS_PREPARE = 6,
  parameter int HS_ZERO_BYTES = 4,
  parameter int T_HS_TRAIL = 8,
  parameter int T_HS_EXIT = 10,
  parameter int CNT_W = 8
) (
  input logic TX_DDR_clk,
  input logic TX_rst_n,
  hs_lane_sequencer_if.slave bus
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic rdy, rdy_nx, ld, clr, b1, b2, last, pre_last, hs_en, stop;
  logic [1:0] lp;
  logic [7:0] d;
  hs_byte_serializer ser (
    .clk(TX_DDR_clk), .rst_n(TX_rst_n), .clr(clr), .ld(ld), .d(d),
    .b1(b1), .b2(b2), .last(last), .pre_last(pre_last)
  );
  always_comb begin
    state_nx = state;
    cnt_nx = cnt - 1'b1;
    rdy_nx = 1'b0;
    ld = 1'b0;
    clr = 1'b0;
    d = '0;
    case (state)
      STOP: if (bus.TxRequestHS) begin
        state_nx = LP_RQST;
        cnt_nx = CNT_W'(T_LPX - 1);
      end
      LP_RQST: if (!bus.TxRequestHS) state_nx = STOP;
      else if (cnt == '0) begin
        state_nx = LP_PREP;
        cnt_nx = CNT_W'(T_HS_PREPARE - 1);
      end
      LP_PREP: if (!bus.TxRequestHS) state_nx = STOP;
      else if (cnt == '0) begin
        state_nx = HS_ZERO;
        cnt_nx = CNT_W'(HS_ZERO_BYTES * 4 - 1);
        ld = 1'b1;
        clr = 1'b1;
      end
      HS_ZERO: if (cnt == '0) begin
        state_nx = SYNC;
        ld = 1'b1;
        d = SYNC_BYTE;
      end
      // TxReadyHS is registered, so the request is sampled one pair early to show ready during the last pair
      SYNC, DATA: begin
        rdy_nx = pre_last && bus.TxRequestHS;
        if (last) begin
          state_nx = rdy ? DATA : TRAIL;
          ld = 1'b1;
          d = rdy ? bus.TxDataHS : {8{~b2}};
          cnt_nx = CNT_W'(T_HS_TRAIL - 1);
        end
      end
      TRAIL: if (cnt == '0) begin
        state_nx = EXIT;
        cnt_nx = CNT_W'(T_HS_EXIT - 1);
        ld = 1'b1;
      end
      EXIT: if (cnt == '0) state_nx = STOP;
    endcase
  end
  always_ff @(posedge TX_DDR_clk or negedge TX_rst_n)
    if (!TX_rst_n) begin
      state <= STOP;
      cnt <= '0;
      rdy <= 1'b0;
      lp <= LP11;
      hs_en <= 1'b0;
      stop <= 1'b1;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      rdy <= rdy_nx;
      lp <= lp_level(state_nx);
      hs_en <= hs_on(state_nx);
      stop <= state_nx == STOP;
    end
  assign bus.TxReadyHS = rdy;
  assign bus.Stopstate = stop;
  assign bus.LP_Dp = lp[1];
  assign bus.LP_Dn = lp[0];
  assign bus.HS_Enable = hs_en;
  assign bus.Serial_B1 = b1;
  assign bus.Serial_B2 = b2;
endmodule

// File: tb/tb_hs_lane_sequencer.sv
// tb_hs_lane_sequencer: randomized scoreboard bench comparing the lane outputs cycle by cycle against a trace model
module tb_hs_lane_sequencer;
  localparam int T_LPX = 8;
  localparam int T_PREP = 6;
  localparam int HSZ = 4;
  localparam int T_TRAIL = 8;
  localparam int T_EXIT = 10;
  typedef logic [6:0] o_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  o_t exp_q[$];
  o_t msk_q[$];
  logic [7:0] bytes[$];
  int compared = 0;
  int mismatched = 0;
  hs_lane_sequencer_if bus ();
  hs_lane_sequencer #(
    .T_LPX(T_LPX), .T_HS_PREPARE(T_PREP), .HS_ZERO_BYTES(HSZ),
    .T_HS_TRAIL(T_TRAIL), .T_HS_EXIT(T_EXIT), .CNT_W(8)
  ) dut (.TX_DDR_clk(clk), .TX_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic o_t act();
    return {bus.TxReadyHS, bus.Stopstate, bus.HS_Enable, bus.LP_Dp, bus.LP_Dn, bus.Serial_B1, bus.Serial_B2};
  endfunction
  function automatic void check(string nm, o_t e, o_t m);
    compared++;
    if ((act() & m) !== (e & m)) begin
      mismatched++;
      $display("FAIL %s t=%0t {rdy,stop,hs,dp,dn,b1,b2} got=%b want=%b care=%b", nm, $time, act(), e, m);
    end
  endfunction
  function automatic void push_lp(bit dp, bit dn, bit st, int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, st, 1'b0, dp, dn, 2'b00});
      msk_q.push_back(7'b1111100);
    end
  endfunction
  function automatic void push_hs(bit b1, bit b2, bit rdy);
    exp_q.push_back({rdy, 1'b0, 1'b1, 2'b00, b1, b2});
    msk_q.push_back(7'b1110011);
  endfunction
  function automatic void model(int n);
    logic [7:0] sb = 8'hB8;
    logic [7:0] lb;
    push_lp(0, 1, 0, T_LPX);
    push_lp(0, 0, 0, T_PREP);
    for (int i = 0; i < 4 * HSZ; i++) push_hs(0, 0, 0);
    for (int p = 0; p < 4; p++) push_hs(sb[2*p], sb[2*p+1], p == 3 && n > 0);
    for (int i = 0; i < n; i++)
      for (int p = 0; p < 4; p++) push_hs(bytes[i][2*p], bytes[i][2*p+1], p == 3 && i < n - 1);
    lb = n > 0 ? bytes[n-1] : sb;
    for (int i = 0; i < T_TRAIL; i++) push_hs(~lb[7], ~lb[7], 0);
    push_lp(1, 1, 0, T_EXIT);
  endfunction
  function automatic void model_abort(int k);
    push_lp(0, 1, 0, k < T_LPX ? k : T_LPX);
    if (k > T_LPX) push_lp(0, 0, 0, k - T_LPX);
  endfunction
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (exp_q.size() > 0) check("trace", exp_q.pop_front(), msk_q.pop_front());
      else check("idle", 7'b0101100, 7'b1111100);
    end
  end
  task automatic drive(input int n, input int limit, input bit must);
    int idx = 0;
    int cyc = 0;
    bit seen = 0;
    bus.TxDataHS = bytes[0];
    bus.TxRequestHS = 1'b1;
    while (idx < n && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (seen) begin
        idx++;
        if (idx == n) bus.TxRequestHS = 1'b0;
        else bus.TxDataHS = bytes[idx];
      end
      seen = bus.TxReadyHS;
    end
    bus.TxRequestHS = 1'b0;
    if (must) begin
      compared++;
      if (idx < n) begin
        mismatched++;
        $display("FAIL handshake accepted=%0d want=%0d", idx, n);
      end
    end
  endtask
  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    compared++;
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
      exp_q.delete();
      msk_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic rand_bytes(input int n);
    bytes.delete();
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom_range(0, 255)));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    bus.TxRequestHS = 1'b0;
    bus.TxDataHS = 8'h00;
    #1 rst_n = 1'b0;
    #2 check("reset", 7'b0101100, 7'b1111111);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    bytes = '{8'hA5};
    model(1);
    drive(1, 300, 1);
    drain();
    bytes = '{8'h01, 8'h80, 8'hFF};
    model(3);
    drive(3, 300, 1);
    drain();
    model_abort(3);
    bus.TxRequestHS = 1'b1;
    repeat (3) @(negedge clk);
    bus.TxRequestHS = 1'b0;
    drain();
    k = T_LPX + $urandom_range(1, T_PREP);
    model_abort(k);
    bus.TxRequestHS = 1'b1;
    repeat (k) @(negedge clk);
    bus.TxRequestHS = 1'b0;
    drain();
    model(0);
    bus.TxRequestHS = 1'b1;
    repeat (T_LPX + T_PREP + 1 + $urandom_range(0, 4 * HSZ - 1)) @(negedge clk);
    bus.TxRequestHS = 1'b0;
    drain();
    for (int r = 0; r < 8; r++) begin
      k = $urandom_range(1, 4);
      rand_bytes(k);
      model(k);
      drive(k, 400, 1);
      drain();
    end
    rand_bytes(3);
    model(3);
    drive(3, T_LPX + T_PREP + 4 * HSZ + 6, 0);
    #1 rst_n = 1'b0;
    exp_q.delete();
    msk_q.delete();
    #1 check("mid_reset", 7'b0101100, 7'b1111111);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rand_bytes(2);
    model(2);
    drive(2, 400, 1);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
